// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state, RV32I load/store funct3 encodings and legality check for lsu_rmw.
package lsu_pkg;
    typedef enum logic [2:0] {IDLE, LD, RD, WR, RESP} state_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                  : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction
endpackage

// File: rtl/lsu_rmw_if.sv
// lsu_rmw_if: core request/response handshake and word-memory port of the LSU.
interface lsu_rmw_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte/halfword lane extraction with extension for loads, lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        ld_data = funct3[1:0] == 2'b00 ? {{24{b[7] & ~funct3[2]}}, b}
                : funct3[1:0] == 2'b01 ? {{16{h[15] & ~funct3[2]}}, h}
                : word;
        st_data = word;
        if (funct3[1:0] == 2'b00)
            st_data[8*off +: 8] = wdata[7:0];
        else if (funct3[1:0] == 2'b01)
            st_data[16*off[1] +: 16] = wdata[15:0];
        else
            st_data = wdata;
    end
endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: byte-addressed RV32I load/store unit in front of a word-only memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of force-aligning them.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input logic     clk,
    input logic     rst_n,
    lsu_rmw_if.slave bus
);
    localparam logic [31:0] ADDR_LIM = 32'(MEM_WORDS * 4);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic        mem_rw_q, mem_rw_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0] ld_data, st_data, addr_al;
    logic        is_h, is_w, misalign, mis_err, req_err;

    assign is_h     = bus.req_funct3[1:0] == 2'b01;
    assign is_w     = bus.req_funct3[1:0] == 2'b10;
    assign misalign = (is_h & bus.req_addr[0]) | (is_w & |bus.req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_err  = misalign;
`else
    assign mis_err  = 1'b0;
`endif
    assign req_err  = !f3_legal(bus.req_we, bus.req_funct3) || bus.req_addr >= ADDR_LIM || mis_err;
    // Alignment is harmless when trapping, since misaligned requests never reach memory then.
    assign addr_al  = {bus.req_addr[31:2], is_w ? 2'b00 : {bus.req_addr[1], bus.req_addr[0] & ~is_h}};

    lsu_lane_align u_align (
        .word    (bus.mem_rdata),
        .wdata   (wdata_q),
        .off     (addr_q[1:0]),
        .funct3  (f3_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: if (bus.req_valid && req_ready_q) begin
                addr_d      = addr_al;
                f3_d        = bus.req_funct3;
                wdata_d     = bus.req_wdata;
                req_ready_d = 1'b0;
                if (req_err) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    state_d     = !bus.req_we ? LD : is_w ? WR : RD;
                    mem_addr_d  = {2'b00, addr_al[31:2]};
                    mem_rw_d    = bus.req_we && is_w;
                    mem_wdata_d = bus.req_we && is_w ? bus.req_wdata : mem_wdata_q;
                end
            end
            LD: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = ld_data;
                mem_addr_d  = '0;
            end
            // The merged word is captured here so the write cycle sees a stable value.
            RD: begin
                state_d     = WR;
                mem_rw_d    = 1'b1;
                mem_wdata_d = st_data;
                mem_addr_d  = {2'b00, addr_q[31:2]};
            end
            WR: begin
                state_d     = RESP;
                mem_rw_d    = 1'b0;
                mem_addr_d  = '0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            RESP: if (bus.rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: vector table + scoreboard bench for lsu_rmw (default build, misaligned accesses force-aligned).
module tb_lsu_rmw;
    import lsu_pkg::*;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wr_off;
        logic [31:0] wr_word;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    int cyc = 0;
    int nwr = 0;
    int wr_cyc = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] mem [32];
    vec_t sb[$];
    vec_t vt[$];

    lsu_rmw_if bus();
    lsu_rmw #(.MEM_WORDS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[1] <= 32'h8081_7F22;
            mem[3] <= 32'h1122_3344;
        end else if (bus.mem_rw === 1'b1)
            mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr[4:0]];

    always @(negedge clk) begin
        if (bus.mem_rw === 1'b1) begin
            nwr     <= nwr + 1;
            wr_cyc  <= cyc;
            wr_addr <= bus.mem_addr;
            wr_data <= bus.mem_wdata;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic e, input int lat, input int wo, input logic [31:0] ww);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.err = e; v.lat = lat; v.wr_off = wo; v.wr_word = ww;
        return v;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin ok = 1; break; end
        end
        chk("req_ready_wait", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.rsp_valid === 1'b1) begin lat = k; break; end
            @(negedge clk);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic run(input vec_t v);
        bit ok;
        int t, w0, lat;
        vec_t e;
        wait_ready(ok);
        if (!ok) return;
        sb.push_back(v);
        t = cyc;
        w0 = nwr;
        drive(v.we, v.f3, v.addr, v.wdata);
        wait_rsp(lat);
        e = sb.pop_front();
        if (lat == 0) begin chk("rsp_timeout", 32'd0, 32'd1); return; end
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        chk("latency", 32'(lat), 32'(e.lat));
        chk("write_count", 32'(nwr - w0), 32'(e.wr_off != 0));
        if (e.wr_off != 0) begin
            chk("write_cycle", 32'(wr_cyc - t), 32'(e.wr_off));
            chk("write_addr", wr_addr, e.addr >> 2);
            chk("write_data", wr_data, e.wr_word);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok, seen;
        int lat, t, w0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
        vt.push_back(mk(0, F3_B,  32'h05, 0, 32'h0000_007F, 0, 2, 0, 0));
        vt.push_back(mk(0, F3_B,  32'h06, 0, 32'hFFFF_FF81, 0, 2, 0, 0));
        vt.push_back(mk(0, F3_BU, 32'h07, 0, 32'h0000_0080, 0, 2, 0, 0));
        vt.push_back(mk(1, F3_W,  32'h08, 32'hDEAD_BEEF, 0, 0, 2, 1, 32'hDEAD_BEEF));
        vt.push_back(mk(0, F3_W,  32'h08, 0, 32'hDEAD_BEEF, 0, 2, 0, 0));
        vt.push_back(mk(1, F3_H,  32'h0E, 32'h1234_AAAA, 0, 0, 3, 2, 32'hAAAA_3344));
        vt.push_back(mk(0, F3_HU, 32'h0C, 0, 32'h0000_3344, 0, 2, 0, 0));
        vt.push_back(mk(0, F3_H,  32'h0E, 0, 32'hFFFF_AAAA, 0, 2, 0, 0));
        vt.push_back(mk(0, F3_W,  32'h06, 0, 32'h8081_7F22, 0, 2, 0, 0));
        vt.push_back(mk(0, F3_W,  32'h80, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 3'b011, 32'h04, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(1, F3_BU, 32'h04, 32'h55, 0, 1, 1, 0, 0));
        vt.push_back(mk(1, F3_B,  32'h04, 32'hFFFF_FF55, 0, 0, 3, 2, 32'h8081_7F55));
        vt.push_back(mk(0, F3_W,  32'h04, 0, 32'h8081_7F55, 0, 2, 0, 0));
        vt.push_back(mk(0, F3_H,  32'h05, 0, 32'h0000_7F55, 0, 2, 0, 0));
        vt.push_back(mk(0, F3_HU, 32'h06, 0, 32'h0000_8081, 0, 2, 0, 0));
        vt.push_back(mk(0, F3_H,  32'h06, 0, 32'hFFFF_8081, 0, 2, 0, 0));
        vt.push_back(mk(1, F3_H,  32'h7D, 32'h0000_BEEF, 0, 0, 3, 2, 32'h0000_BEEF));
        vt.push_back(mk(0, F3_BU, 32'h7D, 0, 32'h0000_00BE, 0, 2, 0, 0));
        vt.push_back(mk(1, F3_B,  32'h7F, 32'h80, 0, 0, 3, 2, 32'h8000_BEEF));
        vt.push_back(mk(0, F3_B,  32'h7F, 0, 32'hFFFF_FF80, 0, 2, 0, 0));
        vt.push_back(mk(1, F3_W,  32'h7E, 32'h0102_0304, 0, 0, 2, 1, 32'h0102_0304));
        vt.push_back(mk(0, F3_W,  32'h7C, 0, 32'h0102_0304, 0, 2, 0, 0));
        vt.push_back(mk(1, F3_W,  32'h80, 32'h1, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, F3_BU, 32'hFFFF_FFFF, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 3'b110, 32'h00, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(1, 3'b111, 32'h00, 0, 0, 1, 1, 0, 0));

        repeat (2) @(negedge clk);
        preload = 1'b0;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;

        foreach (vt[i]) run(vt[i]);

        // Consumer stalls after a SW: response must hold and no extra write may occur.
        wait_ready(ok);
        bus.rsp_ready = 1'b0;
        w0 = nwr;
        drive(1'b1, F3_W, 32'h10, 32'h1234_5678);
        wait_rsp(lat);
        chk("stall_rsp_seen", 32'(lat != 0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("stall_rsp_err", 32'(bus.rsp_err), 32'd0);
        end
        chk("stall_write_count", 32'(nwr - w0), 32'd1);
        chk("stall_write_addr", wr_addr, 32'd4);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("stall_release_ready", 32'(bus.req_ready), 32'd1);
        run(mk(0, F3_W, 32'h10, 0, 32'h1234_5678, 0, 2, 0, 0));

        // Asynchronous reset while an SB sits in its read phase.
        wait_ready(ok);
        w0 = nwr;
        t = cyc;
        drive(1'b1, F3_B, 32'h04, 32'hFFFF_FF99);
        chk("rmw_rd_addr", bus.mem_addr, 32'd1);
        chk("rmw_rd_rw", 32'(bus.mem_rw), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_mem_rw", 32'(bus.mem_rw), 32'd0);
        chk("arst_mem_addr", bus.mem_addr, 32'd0);
        chk("arst_mem_wdata", bus.mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        chk("arst_no_rsp", 32'(seen), 32'd0);
        chk("arst_no_write", 32'(nwr - w0), 32'd0);
        run(mk(0, F3_W, 32'h04, 0, 32'h8081_7F55, 0, 2, 0, 0));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
